vending_fsm_param: RTL and testbench
====================================

Name: vending_fsm_param

Overview:
- Parametrised next-generation vending controller with three coin denominations and a configurable price.
- Tracks credit in 5-cent units and vends when credit reaches PRICE.
- Returns excess credit as a multi-cycle burst of dime/nickel change pulses.
- Also supports cancel/refund, rejects coins while busy, and keeps a wrapping sales counter. Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

Parameters:
- PRICE, 4, item price in 5-cent units (default 20c); legal range 1..(2**CREDIT_W - 5)
- CREDIT_W, 4, width of the credit and change registers; must satisfy PRICE+4 < 2**CREDIT_W
- VAL_N, 1, value of coin code 01 in units (nickel)
- VAL_D, 2, value of coin code 10 in units (dime)
- VAL_Q, 5, value of coin code 11 in units (quarter)
- CNT_W, 8, width of the sales counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- coin  in  2  coin presented this cycle: 00 none, 01 VAL_N, 10 VAL_D, 11 VAL_Q; one-cycle event
- cancel  in  1  refund request, sampled each cycle
- dispense  out  1  registered one-cycle vend pulse
- chg10  out  1  registered one-cycle pulse: hopper returns one dime
- chg5  out  1  registered one-cycle pulse: hopper returns one nickel
- coin_rej  out  1  registered one-cycle pulse: coin sampled last cycle was refused
- busy  out  1  high while change/refund is being paid out
- credit  out  CREDIT_W  current accepted credit, in units
- sold_cnt  out  CNT_W  number of vends since reset; wraps modulo 2**CNT_W

Behaviour:
- Async reset: state=ACCUM; credit, change counter and sold_cnt = 0; all pulse outputs and busy = 0. These values take effect immediately on rst assertion, independent of clk.
- States: ACCUM (accepting coins) and CHANGE (paying out). busy = (state==CHANGE), decoded directly from the state register.
- In ACCUM, coin != 00 and cancel=0:
  - sum = credit + coin value.
  - If sum < PRICE: credit <= sum at the next edge. No pulses.
  - If sum >= PRICE: at the next edge dispense=1 for one cycle, credit <= 0, sold_cnt increments, and excess = sum-PRICE is loaded into the change counter. State goes to CHANGE if excess>0, otherwise stays in ACCUM.
- In ACCUM, cancel=1 with credit>0: change counter <= credit, credit <= 0, state <= CHANGE, no dispense.
  - If coin != 00 in the same cycle, that coin is refused (coin_rej=1 next cycle) and is not refunded through change.
- In ACCUM, cancel=1 with credit=0: no-op. A coin in the same cycle is refused.
- In CHANGE, at each edge with remaining count r:
  - If r >= 2: chg10=1 and r <= r-2.
  - Otherwise: chg5=1 and r <= r-1.
  - When the new r is 0, state <= ACCUM.
  - chg10 and chg5 are never both high in the same cycle. The first change pulse appears on the cycle after dispense.
- In CHANGE, any coin is refused (coin_rej=1 next cycle, credit unchanged) and cancel is ignored.
- Width rules:
  - Credit in ACCUM is always < PRICE, so sum <= PRICE+4 and never overflows CREDIT_W.
  - Maximum excess is VAL_Q-1.
  - sold_cnt wraps from all-ones to 0 with no flag.
- Pulses last exactly one cycle. Back-to-back coins in consecutive cycles are all accepted while in ACCUM.
- Reset asserted mid-CHANGE aborts the payout: the remaining change is lost and no further pulses are issued.

Decomposition:
- Package vending_pkg holds:
  - coin code constants (COIN_NONE, COIN_N, COIN_D, COIN_Q)
  - the state enum (ACCUM, CHANGE)
  - a function mapping coin code to unit value from the VAL_* parameters
- Sub-module change_payout, a natural split:
  - loadable down-counter of width CREDIT_W
  - inputs: load, load_val
  - outputs: chg10, chg5, done
  - implements the dime-first pulse sequencing
- The top level keeps the ACCUM logic, the credit register and sold_cnt.

Test Plan (PRICE=4, defaults):
- Dime, dime in consecutive cycles -> credit 2 after the first; dispense=1 one cycle after the second; no chg pulses; credit=0; sold_cnt=1; busy stays 0.
- Nickel then quarter -> dispense cycle N+1, chg10 at N+2, busy high for exactly 1 cycle, then back to ACCUM with credit 0.
- Nickel, dime, quarter -> sum 8, excess 4 -> dispense, then chg10, chg10 on the next two cycles; chg5 never asserted.
- Nickel, cancel -> chg5 single pulse, no dispense. Dime+nickel then cancel asserted together with a coin -> chg10, chg5 pulses, plus coin_rej=1 for the simultaneous coin.
- Coin presented while busy=1 -> coin_rej=1 next cycle; credit stays 0 after payout completes.
- Assert rst asynchronously (between clock edges) mid-CHANGE -> chg10/chg5/busy drop to 0 immediately, no further pulses. With CNT_W=2, 4 completed vends -> sold_cnt wraps to 0.

Source files
------------

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared coin codes, FSM states and coin valuation for the vending controller
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_N    = 2'b01;
    localparam logic [1:0] COIN_D    = 2'b10;
    localparam logic [1:0] COIN_Q    = 2'b11;

    typedef enum logic {
        ACCUM  = 1'b0,
        CHANGE = 1'b1
    } state_t;

    function automatic int coin_value(
        input logic [1:0] code,
        input int         val_n,
        input int         val_d,
        input int         val_q
    );
        case (code)
            COIN_N:  return val_n;
            COIN_D:  return val_d;
            COIN_Q:  return val_q;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/change_payout.sv
// rtl/change_payout.sv - loadable change down-counter issuing dime-first hopper pulses
module change_payout #(
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    output logic                chg10,
    output logic                chg5,
    output logic                done
);

    logic [CREDIT_W-1:0] remaining;
    logic                take_dime;

    assign take_dime = (remaining >= CREDIT_W'(2));
    // High on the edge that pays out the last coin, so the owner can leave CHANGE in step.
    assign done = (remaining == CREDIT_W'(1)) || (remaining == CREDIT_W'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            chg10     <= 1'b0;
            chg5      <= 1'b0;
        end else begin
            chg10 <= 1'b0;
            chg5  <= 1'b0;
            if (load) begin
                remaining <= load_val;
            end else if (remaining != '0) begin
                if (take_dime) begin
                    chg10     <= 1'b1;
                    remaining <= remaining - CREDIT_W'(2);
                end else begin
                    chg5      <= 1'b1;
                    remaining <= remaining - CREDIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vending_fsm_param.sv
// rtl/vending_fsm_param.sv - parametrised vending controller: credit, vend, refund and change payout
module vending_fsm_param
    import vending_pkg::*;
#(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 4,
    parameter int VAL_N    = 1,
    parameter int VAL_D    = 2,
    parameter int VAL_Q    = 5,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                dispense,
    output logic                chg10,
    output logic                chg5,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [CNT_W-1:0]    sold_cnt
);

    localparam int SW = CREDIT_W + 1;

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W:0]   coin_units, sum, price_ext;
    logic                dispense_nxt, rej_nxt, sold_inc;
    logic                load, pay_done;
    logic [CREDIT_W-1:0] load_val;

    assign price_ext  = SW'(PRICE);
    assign coin_units = SW'(coin_value(coin, VAL_N, VAL_D, VAL_Q));
    // One spare bit: credit < PRICE so the sum cannot exceed PRICE + VAL_Q - 1.
    assign sum        = {1'b0, credit} + coin_units;
    assign busy       = (state == CHANGE);

    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        dispense_nxt = 1'b0;
        rej_nxt      = 1'b0;
        sold_inc     = 1'b0;
        load         = 1'b0;
        load_val     = '0;
        case (state)
            ACCUM: begin
                if (cancel) begin
                    rej_nxt = (coin != COIN_NONE);
                    if (credit != '0) begin
                        load       = 1'b1;
                        load_val   = credit;
                        credit_nxt = '0;
                        state_nxt  = CHANGE;
                    end
                end else if (coin != COIN_NONE) begin
                    if (sum < price_ext) begin
                        credit_nxt = CREDIT_W'(sum);
                    end else begin
                        dispense_nxt = 1'b1;
                        sold_inc     = 1'b1;
                        credit_nxt   = '0;
                        load         = 1'b1;
                        load_val     = CREDIT_W'(sum - price_ext);
                        if (sum != price_ext) state_nxt = CHANGE;
                    end
                end
            end
            CHANGE: begin
                rej_nxt = (coin != COIN_NONE);
                if (pay_done) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACCUM;
            credit   <= '0;
            sold_cnt <= '0;
            dispense <= 1'b0;
            coin_rej <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            dispense <= dispense_nxt;
            coin_rej <= rej_nxt;
            if (sold_inc) sold_cnt <= sold_cnt + CNT_W'(1);
        end
    end

    change_payout #(
        .CREDIT_W(CREDIT_W)
    ) u_payout (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .chg10   (chg10),
        .chg5    (chg5),
        .done    (pay_done)
    );

endmodule

// File: tb/tb_vending_fsm_param.sv
// tb/tb_vending_fsm_param.sv - self-checking bench for vending_fsm_param (vectors, corner sequences, random vs model)
module tb_vending_fsm_param;

    localparam int PRICE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;

    logic       dispense, chg10, chg5, coin_rej, busy;
    logic [3:0] credit;
    logic [7:0] sold_cnt;
    logic       d2_dispense, d2_chg10, d2_chg5, d2_coin_rej, d2_busy;
    logic [3:0] d2_credit;
    logic [1:0] d2_sold_cnt;

    int passed = 0;
    int total  = 0;

    int coin_val [4] = '{0, 1, 2, 5};
    int m_credit, m_sold;
    int pay_q [$];
    int e_disp, e_c10, e_c5, e_rej;

    typedef struct {
        logic [1:0] c;
        logic       cx;
        int         disp, c10, c5, rej, bsy, cred, sold;
    } vec_t;
    vec_t vecs [$];

    vending_fsm_param dut (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
        .dispense(dispense), .chg10(chg10), .chg5(chg5), .coin_rej(coin_rej),
        .busy(busy), .credit(credit), .sold_cnt(sold_cnt)
    );

    vending_fsm_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
        .dispense(d2_dispense), .chg10(d2_chg10), .chg5(d2_chg5), .coin_rej(d2_coin_rej),
        .busy(d2_busy), .credit(d2_credit), .sold_cnt(d2_sold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act === 32'(exp)) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_outputs(input string tag, input int ed, input int ec10, input int ec5,
                                 input int erej, input int ebusy, input int ecred, input int esold);
        chk({tag, " dispense"}, 32'(dispense), ed);
        chk({tag, " chg10"},    32'(chg10),    ec10);
        chk({tag, " chg5"},     32'(chg5),     ec5);
        chk({tag, " coin_rej"}, 32'(coin_rej), erej);
        chk({tag, " busy"},     32'(busy),     ebusy);
        chk({tag, " credit"},   32'(credit),   ecred);
        chk({tag, " sold_cnt"}, 32'(sold_cnt), esold % 256);
        chk({tag, " sold_cnt_w2"}, 32'(d2_sold_cnt), esold % 4);
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_sold   = 0;
        pay_q.delete();
    endtask

    task automatic owe(input int amount);
        for (int i = 0; i < amount / 2; i++) pay_q.push_back(10);
        if (amount % 2 == 1) pay_q.push_back(5);
    endtask

    // Expected outputs after one clock edge with the given inputs.
    task automatic model_step(input logic [1:0] c, input logic cx);
        int p;
        e_disp = 0; e_c10 = 0; e_c5 = 0; e_rej = 0;
        if (pay_q.size() > 0) begin
            e_rej = (c != 0);
            p = pay_q.pop_front();
            if (p == 10) e_c10 = 1; else e_c5 = 1;
        end else if (cx) begin
            e_rej = (c != 0);
            if (m_credit > 0) begin
                owe(m_credit);
                m_credit = 0;
            end
        end else if (c != 0) begin
            if (m_credit + coin_val[c] >= PRICE) begin
                e_disp = 1;
                m_sold++;
                owe(m_credit + coin_val[c] - PRICE);
                m_credit = 0;
            end else begin
                m_credit += coin_val[c];
            end
        end
    endtask

    task automatic apply(input logic [1:0] c, input logic cx);
        @(negedge clk);
        coin   = c;
        cancel = cx;
        @(posedge clk);
        model_step(c, cx);
        #1;
        coin   = 2'b00;
        cancel = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check_outputs(tag, e_disp, e_c10, e_c5, e_rej, (pay_q.size() > 0) ? 1 : 0, m_credit, m_sold);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
        #10 rst = 1'b0;

        //            coin  cx   dsp c10 c5 rej bsy cred sold
        vecs.push_back('{2'd2, 1'b0, 0, 0, 0, 0, 0, 2, 0});
        vecs.push_back('{2'd2, 1'b0, 1, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{2'd0, 1'b0, 0, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{2'd1, 1'b0, 0, 0, 0, 0, 0, 1, 1});
        vecs.push_back('{2'd3, 1'b0, 1, 0, 0, 0, 1, 0, 2});
        vecs.push_back('{2'd0, 1'b0, 0, 1, 0, 0, 0, 0, 2});
        vecs.push_back('{2'd0, 1'b0, 0, 0, 0, 0, 0, 0, 2});
        vecs.push_back('{2'd1, 1'b0, 0, 0, 0, 0, 0, 1, 2});
        vecs.push_back('{2'd2, 1'b0, 0, 0, 0, 0, 0, 3, 2});
        vecs.push_back('{2'd3, 1'b0, 1, 0, 0, 0, 1, 0, 3});
        vecs.push_back('{2'd0, 1'b0, 0, 1, 0, 0, 1, 0, 3});
        vecs.push_back('{2'd0, 1'b0, 0, 1, 0, 0, 0, 0, 3});
        vecs.push_back('{2'd1, 1'b0, 0, 0, 0, 0, 0, 1, 3});
        vecs.push_back('{2'd0, 1'b1, 0, 0, 0, 0, 1, 0, 3});
        vecs.push_back('{2'd0, 1'b0, 0, 0, 1, 0, 0, 0, 3});
        vecs.push_back('{2'd2, 1'b0, 0, 0, 0, 0, 0, 2, 3});
        vecs.push_back('{2'd1, 1'b0, 0, 0, 0, 0, 0, 3, 3});
        vecs.push_back('{2'd2, 1'b1, 0, 0, 0, 1, 1, 0, 3});
        vecs.push_back('{2'd0, 1'b0, 0, 1, 0, 0, 1, 0, 3});
        vecs.push_back('{2'd0, 1'b0, 0, 0, 1, 0, 0, 0, 3});
        vecs.push_back('{2'd3, 1'b0, 1, 0, 0, 0, 1, 0, 4});
        vecs.push_back('{2'd2, 1'b0, 0, 0, 1, 1, 0, 0, 4});
        vecs.push_back('{2'd0, 1'b0, 0, 0, 0, 0, 0, 0, 4});
        vecs.push_back('{2'd1, 1'b1, 0, 0, 0, 1, 0, 0, 4});
        vecs.push_back('{2'd0, 1'b1, 0, 0, 0, 0, 0, 0, 4});
        vecs.push_back('{2'd2, 1'b0, 0, 0, 0, 0, 0, 2, 4});
        vecs.push_back('{2'd1, 1'b0, 0, 0, 0, 0, 0, 3, 4});
        vecs.push_back('{2'd3, 1'b0, 1, 0, 0, 0, 1, 0, 5});
        vecs.push_back('{2'd0, 1'b1, 0, 1, 0, 0, 1, 0, 5});
        vecs.push_back('{2'd0, 1'b0, 0, 1, 0, 0, 0, 0, 5});

        foreach (vecs[i]) begin
            apply(vecs[i].c, vecs[i].cx);
            check_outputs($sformatf("vec%0d", i), vecs[i].disp, vecs[i].c10, vecs[i].c5,
                          vecs[i].rej, vecs[i].bsy, vecs[i].cred, vecs[i].sold);
        end

        // Asynchronous reset in the middle of a four-unit payout.
        apply(2'd1, 1'b0);
        apply(2'd2, 1'b0);
        apply(2'd3, 1'b0);
        check_model("pre_rst_vend");
        apply(2'd0, 1'b0);
        check_model("pre_rst_pay");
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(2'd0, 1'b0);
            check_model($sformatf("post_rst%0d", i));
        end

        // Four exact-price vends wrap the 2-bit counter.
        for (int i = 0; i < 4; i++) begin
            apply(2'd2, 1'b0);
            apply(2'd2, 1'b0);
        end
        chk("wrap sold_cnt_w2", 32'(d2_sold_cnt), 0);
        chk("wrap sold_cnt", 32'(sold_cnt), 4);

        for (int i = 0; i < 600; i++) begin
            logic [1:0] c;
            logic       cx;
            c  = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
            cx = ($urandom_range(0, 7) == 0);
            apply(c, cx);
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
